// File: rtl/axis_packet_arbiter_pkg.sv
// Shared helpers for the AXI-Stream packet arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE / LOCKED)
//   log2        : ceiling log2 used to size port-index fields (minimum 1)
package axis_packet_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// One-stage AXI-Stream register slice carrying encoded tkeep and the tuser
// routing fields.
//   clk_i / rst_i          : clock, asynchronous active-high reset
//   s_*_i / s_tready_o     : upstream beat and ready
//   m_*_o / m_tready_i     : registered downstream beat and ready
module axis_reg_slice #(
  parameter int C_DATA_W = 256,
  parameter int C_KEEP_W = 5,
  parameter int C_LEN_W  = 14,
  parameter int C_IN_W   = 3,
  parameter int C_OUT_W  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                s_tvalid_i,
  output logic                s_tready_o,
  input  logic                s_tlast_i,
  input  logic [C_DATA_W-1:0] s_tdata_i,
  input  logic [C_KEEP_W-1:0] s_tkeep_enc_i,
  input  logic [C_LEN_W-1:0]  s_len_i,
  input  logic [C_IN_W-1:0]   s_in_port_i,
  input  logic [C_IN_W-1:0]   s_in_vport_i,
  input  logic [C_OUT_W-1:0]  s_out_port_i,
  input  logic [C_OUT_W-1:0]  s_out_vport_i,
  output logic                m_tvalid_o,
  input  logic                m_tready_i,
  output logic                m_tlast_o,
  output logic [C_DATA_W-1:0] m_tdata_o,
  output logic [C_KEEP_W-1:0] m_tkeep_enc_o,
  output logic [C_LEN_W-1:0]  m_len_o,
  output logic [C_IN_W-1:0]   m_in_port_o,
  output logic [C_IN_W-1:0]   m_in_vport_o,
  output logic [C_OUT_W-1:0]  m_out_port_o,
  output logic [C_OUT_W-1:0]  m_out_vport_o
);

  logic                tvalid_q, tlast_q;
  logic [C_DATA_W-1:0] tdata_q;
  logic [C_KEEP_W-1:0] tkeep_q;
  logic [C_LEN_W-1:0]  len_q;
  logic [C_IN_W-1:0]   in_port_q, in_vport_q;
  logic [C_OUT_W-1:0]  out_port_q, out_vport_q;
  logic                load;

  assign load       = !tvalid_q || m_tready_i;
  assign s_tready_o = load;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      len_q       <= '0;
      in_port_q   <= '0;
      in_vport_q  <= '0;
      out_port_q  <= '0;
      out_vport_q <= '0;
    end else if (load) begin
      tvalid_q <= s_tvalid_i;
      // Payload only moves with a real beat so idle outputs stay quiet.
      if (s_tvalid_i) begin
        tlast_q     <= s_tlast_i;
        tdata_q     <= s_tdata_i;
        tkeep_q     <= s_tkeep_enc_i;
        len_q       <= s_len_i;
        in_port_q   <= s_in_port_i;
        in_vport_q  <= s_in_vport_i;
        out_port_q  <= s_out_port_i;
        out_vport_q <= s_out_vport_i;
      end
    end
  end

  assign m_tvalid_o    = tvalid_q;
  assign m_tlast_o     = tlast_q;
  assign m_tdata_o     = tdata_q;
  assign m_tkeep_enc_o = tkeep_q;
  assign m_len_o       = len_q;
  assign m_in_port_o   = in_port_q;
  assign m_in_vport_o  = in_vport_q;
  assign m_out_port_o  = out_port_q;
  assign m_out_vport_o = out_vport_q;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Round-robin AXI-Stream arbiter with packet-granular grants.
//   axi_aclk / axi_reset     : clock, asynchronous active-high reset
//   s_axis_*                 : C_NUM_PORTS slave streams, port i in slice i
//   m_axis_*                 : registered merged stream
//   grant_port               : currently / last granted port
//   busy                     : a packet is granted (state LOCKED)
module axis_packet_arbiter
  import axis_packet_arbiter_pkg::*;
#(
  parameter int C_NUM_PORTS           = 4,
  parameter int C_AXIS_DATA_WIDTH     = 256,
  parameter int C_TKEEP_ENC_WIDTH     = 5,
  parameter int C_PACKET_LENGTH_WIDTH = 14,
  parameter int C_INPORT_WIDTH        = 3,
  parameter int C_OUTPORT_WIDTH       = 8,
  parameter int C_GRANT_W             = log2(C_NUM_PORTS)
) (
  input  logic                                         axi_aclk,
  input  logic                                         axi_reset,
  input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_NUM_PORTS*C_TKEEP_ENC_WIDTH-1:0]     s_axis_tkeep_enc,
  input  logic [C_NUM_PORTS*C_PACKET_LENGTH_WIDTH-1:0] s_axis_tuser_packet_length,
  input  logic [C_NUM_PORTS*C_INPORT_WIDTH-1:0]        s_axis_tuser_in_port,
  input  logic [C_NUM_PORTS*C_INPORT_WIDTH-1:0]        s_axis_tuser_in_vport,
  input  logic [C_NUM_PORTS*C_OUTPORT_WIDTH-1:0]       s_axis_tuser_out_port,
  input  logic [C_NUM_PORTS*C_OUTPORT_WIDTH-1:0]       s_axis_tuser_out_vport,
  input  logic [C_NUM_PORTS-1:0]                       s_axis_tvalid,
  input  logic [C_NUM_PORTS-1:0]                       s_axis_tlast,
  output logic [C_NUM_PORTS-1:0]                       s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
  output logic [C_TKEEP_ENC_WIDTH-1:0]                 m_axis_tkeep_enc,
  output logic [C_PACKET_LENGTH_WIDTH-1:0]             m_axis_tuser_packet_length,
  output logic [C_INPORT_WIDTH-1:0]                    m_axis_tuser_in_port,
  output logic [C_OUTPORT_WIDTH-1:0]                   m_axis_tuser_out_port,
  output logic [C_INPORT_WIDTH-1:0]                    m_axis_tuser_in_vport,
  output logic [C_OUTPORT_WIDTH-1:0]                   m_axis_tuser_out_vport,
  output logic                                         m_axis_tvalid,
  output logic                                         m_axis_tlast,
  input  logic                                         m_axis_tready,
  output logic [C_GRANT_W-1:0]                         grant_port,
  output logic                                         busy
);

  localparam logic [C_GRANT_W:0]   C_N_EXT    = (C_GRANT_W+1)'(C_NUM_PORTS);
  localparam logic [C_GRANT_W-1:0] C_LAST_RST = C_GRANT_W'(C_NUM_PORTS-1);

  arb_state_e                       state_q, state_d;
  logic [C_GRANT_W-1:0]             grant_q, grant_d;
  logic [C_GRANT_W-1:0]             last_grant_q, last_grant_d;
  logic [C_GRANT_W-1:0]             winner;
  logic [C_GRANT_W:0]               cand;
  logic                             winner_found;
  logic                             slice_ready;
  logic                             sel_valid, sel_last;
  logic [C_AXIS_DATA_WIDTH-1:0]     sel_data;
  logic [C_TKEEP_ENC_WIDTH-1:0]     sel_keep;
  logic [C_PACKET_LENGTH_WIDTH-1:0] sel_len;
  logic [C_INPORT_WIDTH-1:0]        sel_in_port, sel_in_vport;
  logic [C_OUTPORT_WIDTH-1:0]       sel_out_port, sel_out_vport;

  always_ff @(posedge axi_aclk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= C_LAST_RST;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Round-robin search starting one past the last winner, wrapping at N.
  always_comb begin
    winner_found = 1'b0;
    winner       = last_grant_q;
    cand         = '0;
    for (int i = 1; i <= C_NUM_PORTS; i++) begin
      cand = {1'b0, last_grant_q} + (C_GRANT_W+1)'(i);
      if (cand >= C_N_EXT) cand = cand - C_N_EXT;
      if (!winner_found && s_axis_tvalid[cand[C_GRANT_W-1:0]]) begin
        winner_found = 1'b1;
        winner       = cand[C_GRANT_W-1:0];
      end
    end
  end

  always_comb begin
    sel_valid     = 1'b0;
    sel_last      = 1'b0;
    sel_data      = '0;
    sel_keep      = '0;
    sel_len       = '0;
    sel_in_port   = '0;
    sel_in_vport  = '0;
    sel_out_port  = '0;
    sel_out_vport = '0;
    s_axis_tready = '0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      if (grant_q == C_GRANT_W'(p)) begin
        sel_valid     = s_axis_tvalid[p];
        sel_last      = s_axis_tlast[p];
        sel_data      = s_axis_tdata[p*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
        sel_keep      = s_axis_tkeep_enc[p*C_TKEEP_ENC_WIDTH +: C_TKEEP_ENC_WIDTH];
        sel_len       = s_axis_tuser_packet_length[p*C_PACKET_LENGTH_WIDTH +: C_PACKET_LENGTH_WIDTH];
        sel_in_port   = s_axis_tuser_in_port[p*C_INPORT_WIDTH +: C_INPORT_WIDTH];
        sel_in_vport  = s_axis_tuser_in_vport[p*C_INPORT_WIDTH +: C_INPORT_WIDTH];
        sel_out_port  = s_axis_tuser_out_port[p*C_OUTPORT_WIDTH +: C_OUTPORT_WIDTH];
        sel_out_vport = s_axis_tuser_out_vport[p*C_OUTPORT_WIDTH +: C_OUTPORT_WIDTH];
        s_axis_tready[p] = (state_q == ST_LOCKED) && slice_ready;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (winner_found) begin
          state_d      = ST_LOCKED;
          grant_d      = winner;
          last_grant_d = winner;
        end
      end
      ST_LOCKED: begin
        // No timeout: a stalled granted port keeps the grant.
        if (sel_valid && slice_ready && sel_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  axis_reg_slice #(
    .C_DATA_W (C_AXIS_DATA_WIDTH),
    .C_KEEP_W (C_TKEEP_ENC_WIDTH),
    .C_LEN_W  (C_PACKET_LENGTH_WIDTH),
    .C_IN_W   (C_INPORT_WIDTH),
    .C_OUT_W  (C_OUTPORT_WIDTH)
  ) u_out_slice (
    .clk_i         (axi_aclk),
    .rst_i         (axi_reset),
    .s_tvalid_i    ((state_q == ST_LOCKED) && sel_valid),
    .s_tready_o    (slice_ready),
    .s_tlast_i     (sel_last),
    .s_tdata_i     (sel_data),
    .s_tkeep_enc_i (sel_keep),
    .s_len_i       (sel_len),
    .s_in_port_i   (sel_in_port),
    .s_in_vport_i  (sel_in_vport),
    .s_out_port_i  (sel_out_port),
    .s_out_vport_i (sel_out_vport),
    .m_tvalid_o    (m_axis_tvalid),
    .m_tready_i    (m_axis_tready),
    .m_tlast_o     (m_axis_tlast),
    .m_tdata_o     (m_axis_tdata),
    .m_tkeep_enc_o (m_axis_tkeep_enc),
    .m_len_o       (m_axis_tuser_packet_length),
    .m_in_port_o   (m_axis_tuser_in_port),
    .m_in_vport_o  (m_axis_tuser_in_vport),
    .m_out_port_o  (m_axis_tuser_out_port),
    .m_out_vport_o (m_axis_tuser_out_vport)
  );

  assign grant_port = grant_q;
  assign busy       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
module tb_axis_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 256;
  localparam int KW = 5;
  localparam int LW = 14;
  localparam int IW = 3;
  localparam int OW = 8;
  localparam int TUW = KW + LW + IW + IW + OW + OW;

  logic             axi_aclk = 1'b0;
  logic             axi_reset;
  logic [N*DW-1:0]  s_axis_tdata;
  logic [N*KW-1:0]  s_axis_tkeep_enc;
  logic [N*LW-1:0]  s_axis_tuser_packet_length;
  logic [N*IW-1:0]  s_axis_tuser_in_port, s_axis_tuser_in_vport;
  logic [N*OW-1:0]  s_axis_tuser_out_port, s_axis_tuser_out_vport;
  logic [N-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DW-1:0]    m_axis_tdata;
  logic [KW-1:0]    m_axis_tkeep_enc;
  logic [LW-1:0]    m_axis_tuser_packet_length;
  logic [IW-1:0]    m_axis_tuser_in_port, m_axis_tuser_in_vport;
  logic [OW-1:0]    m_axis_tuser_out_port, m_axis_tuser_out_vport;
  logic             m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]       grant_port;
  logic             busy;

  always #5 axi_aclk = ~axi_aclk;

  axis_packet_arbiter #(
    .C_NUM_PORTS(N), .C_AXIS_DATA_WIDTH(DW), .C_TKEEP_ENC_WIDTH(KW),
    .C_PACKET_LENGTH_WIDTH(LW), .C_INPORT_WIDTH(IW), .C_OUTPORT_WIDTH(OW)
  ) dut (
    .axi_aclk(axi_aclk), .axi_reset(axi_reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep_enc(s_axis_tkeep_enc),
    .s_axis_tuser_packet_length(s_axis_tuser_packet_length),
    .s_axis_tuser_in_port(s_axis_tuser_in_port), .s_axis_tuser_in_vport(s_axis_tuser_in_vport),
    .s_axis_tuser_out_port(s_axis_tuser_out_port), .s_axis_tuser_out_vport(s_axis_tuser_out_vport),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep_enc(m_axis_tkeep_enc),
    .m_axis_tuser_packet_length(m_axis_tuser_packet_length),
    .m_axis_tuser_in_port(m_axis_tuser_in_port), .m_axis_tuser_out_port(m_axis_tuser_out_port),
    .m_axis_tuser_in_vport(m_axis_tuser_in_vport), .m_axis_tuser_out_vport(m_axis_tuser_out_vport),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .grant_port(grant_port), .busy(busy)
  );

  int pass_n = 0;
  int total_n = 0;
  int cyc = 0;

  // Source model: per-port FIFO of {last, port, pkt, beat}.
  logic [24:0] src_mem [N][16];
  int          head [N];
  int          tail [N];

  // Sink record of accepted master beats.
  logic [DW-1:0]  obs_data  [64];
  logic [TUW-1:0] obs_tuser [64];
  logic           obs_last  [64];
  logic [1:0]     obs_grant [64];
  int             obs_cyc   [64];
  int             obs_n;
  logic           vhist [1024];

  function automatic logic [DW-1:0] exp_data(input logic [23:0] id);
    logic [31:0] w;
    w = {8'hA5, id};
    return {8{w}};
  endfunction

  function automatic logic [TUW-1:0] exp_tuser(input int p, input int b);
    return {KW'(b), LW'(100 + p), IW'(p), IW'(7 - p), OW'(1 << p), OW'(8'h80 | p)};
  endfunction

  function automatic logic [TUW-1:0] m_tuser();
    return {m_axis_tkeep_enc, m_axis_tuser_packet_length, m_axis_tuser_in_port,
            m_axis_tuser_in_vport, m_axis_tuser_out_port, m_axis_tuser_out_vport};
  endfunction

  task automatic drive_sources();
    logic [24:0] e;
    logic [TUW-1:0] tu;
    for (int p = 0; p < N; p++) begin
      if (head[p] < tail[p]) begin
        e  = src_mem[p][head[p]];
        tu = exp_tuser(p, int'(e[7:0]));
        s_axis_tvalid[p] = 1'b1;
        s_axis_tlast[p]  = e[24];
        s_axis_tdata[p*DW +: DW] = exp_data(e[23:0]);
        {s_axis_tkeep_enc[p*KW +: KW], s_axis_tuser_packet_length[p*LW +: LW],
         s_axis_tuser_in_port[p*IW +: IW], s_axis_tuser_in_vport[p*IW +: IW],
         s_axis_tuser_out_port[p*OW +: OW], s_axis_tuser_out_vport[p*OW +: OW]} = tu;
      end else begin
        s_axis_tvalid[p] = 1'b0;
        s_axis_tlast[p]  = 1'b0;
        s_axis_tdata[p*DW +: DW] = '0;
        {s_axis_tkeep_enc[p*KW +: KW], s_axis_tuser_packet_length[p*LW +: LW],
         s_axis_tuser_in_port[p*IW +: IW], s_axis_tuser_in_vport[p*IW +: IW],
         s_axis_tuser_out_port[p*OW +: OW], s_axis_tuser_out_vport[p*OW +: OW]} = '0;
      end
    end
  endtask

  task automatic push_pkt(input int p, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) begin
      src_mem[p][tail[p]] = {(b == nb - 1), 8'(p), 8'(pkt), 8'(b)};
      tail[p] = tail[p] + 1;
    end
    drive_sources();
  endtask

  task automatic flush_src();
    for (int p = 0; p < N; p++) begin
      head[p] = 0;
      tail[p] = 0;
    end
    drive_sources();
  endtask

  // One clock: sample at the falling edge, update sources just after the rise.
  task automatic tick();
    logic [N-1:0] hs;
    cyc = cyc + 1;
    @(negedge axi_aclk);
    hs = s_axis_tvalid & s_axis_tready;
    if (cyc < 1024) vhist[cyc] = m_axis_tvalid;
    if (m_axis_tvalid && m_axis_tready && obs_n < 64) begin
      obs_data[obs_n]  = m_axis_tdata;
      obs_tuser[obs_n] = m_tuser();
      obs_last[obs_n]  = m_axis_tlast;
      obs_grant[obs_n] = grant_port;
      obs_cyc[obs_n]   = cyc;
      obs_n = obs_n + 1;
    end
    @(posedge axi_aclk);
    #1;
    for (int p = 0; p < N; p++) if (hs[p]) head[p] = head[p] + 1;
    drive_sources();
  endtask

  task automatic run_until(input int target, input int budget);
    int k;
    k = 0;
    while (obs_n < target && k < budget) begin
      tick();
      k = k + 1;
    end
  endtask

  task automatic test_reset();
    axi_reset = 1'b1;
    m_axis_tready = 1'b1;
    flush_src();
    repeat (2) @(posedge axi_aclk);
    #1;
    total_n++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); else pass_n++;
    total_n++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast: got %b expected 0", m_axis_tlast); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_n++;
    total_n++; if (grant_port !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", grant_port); else pass_n++;
    total_n++; if (s_axis_tready !== 4'b0000) $display("FAIL reset_tready: got %b expected 0000", s_axis_tready); else pass_n++;
    total_n++; if (m_axis_tdata !== '0) $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); else pass_n++;
    total_n++; if (m_tuser() !== '0) $display("FAIL reset_tuser: got %h expected 0", m_tuser()); else pass_n++;
    axi_reset = 1'b0;
    tick();
    total_n++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else pass_n++;
  endtask

  task automatic test_round_robin();
    int s, p, b;
    obs_n = 0;
    s = cyc;
    for (int q = 0; q < N; q++) push_pkt(q, 1, 2);
    run_until(8, 40);
    total_n++; if (obs_n !== 8) $display("FAIL rr_count: got %0d expected 8", obs_n); else pass_n++;
    total_n++; if (obs_cyc[0] !== s + 3) $display("FAIL rr_latency: got cycle %0d expected %0d", obs_cyc[0], s + 3); else pass_n++;
    for (int i = 0; i < 8 && i < obs_n; i++) begin
      p = i / 2;
      b = i % 2;
      total_n++; if (obs_data[i] !== exp_data({8'(p), 8'd1, 8'(b)})) $display("FAIL rr_data[%0d]: got %h expected port %0d beat %0d", i, obs_data[i][23:0], p, b); else pass_n++;
      total_n++; if (obs_tuser[i] !== exp_tuser(p, b)) $display("FAIL rr_tuser[%0d]: got %h expected %h", i, obs_tuser[i], exp_tuser(p, b)); else pass_n++;
      total_n++; if (obs_last[i] !== (b == 1)) $display("FAIL rr_last[%0d]: got %b expected %b", i, obs_last[i], (b == 1)); else pass_n++;
      total_n++; if (obs_cyc[i] - obs_cyc[0] !== (i / 2) * 3 + (i % 2)) $display("FAIL rr_timing[%0d]: got offset %0d expected %0d", i, obs_cyc[i] - obs_cyc[0], (i / 2) * 3 + (i % 2)); else pass_n++;
      if (b == 0) begin
        total_n++; if (obs_grant[i] !== 2'(p)) $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, obs_grant[i], p); else pass_n++;
      end
    end
    repeat (3) tick();
    flush_src();
  endtask

  task automatic test_back_to_back();
    obs_n = 0;
    for (int k = 1; k <= 3; k++) push_pkt(2, k, 1);
    run_until(3, 30);
    total_n++; if (obs_n !== 3) $display("FAIL b2b_count: got %0d expected 3", obs_n); else pass_n++;
    for (int i = 0; i < 3 && i < obs_n; i++) begin
      total_n++; if (obs_data[i] !== exp_data({8'd2, 8'(i + 1), 8'd0})) $display("FAIL b2b_data[%0d]: got %h", i, obs_data[i][23:0]); else pass_n++;
      total_n++; if (obs_last[i] !== 1'b1) $display("FAIL b2b_last[%0d]: got %b expected 1", i, obs_last[i]); else pass_n++;
      total_n++; if (obs_grant[i] !== 2'd2) $display("FAIL b2b_grant[%0d]: got %0d expected 2", i, obs_grant[i]); else pass_n++;
    end
    if (obs_n == 3) begin
      for (int j = 0; j < 5; j++) begin
        total_n++; if (vhist[obs_cyc[0] + j] !== (j % 2 == 0)) $display("FAIL b2b_valid_pattern[%0d]: got %b expected %b", j, vhist[obs_cyc[0] + j], (j % 2 == 0)); else pass_n++;
      end
    end
    repeat (3) tick();
    flush_src();
  endtask

  task automatic test_hold_off();
    obs_n = 0;
    push_pkt(1, 1, 4);
    run_until(1, 20);
    push_pkt(0, 1, 2);
    run_until(6, 40);
    total_n++; if (obs_n !== 6) $display("FAIL hold_count: got %0d expected 6", obs_n); else pass_n++;
    for (int i = 0; i < 6 && i < obs_n; i++) begin
      if (i < 4) begin
        total_n++; if (obs_data[i] !== exp_data({8'd1, 8'd1, 8'(i)})) $display("FAIL hold_data[%0d]: got %h expected port 1 beat %0d", i, obs_data[i][23:0], i); else pass_n++;
      end else begin
        total_n++; if (obs_data[i] !== exp_data({8'd0, 8'd1, 8'(i - 4)})) $display("FAIL hold_data[%0d]: got %h expected port 0 beat %0d", i, obs_data[i][23:0], i - 4); else pass_n++;
      end
    end
    if (obs_n == 6) begin
      total_n++; if (obs_grant[0] !== 2'd1) $display("FAIL hold_grant_first: got %0d expected 1", obs_grant[0]); else pass_n++;
      total_n++; if (obs_grant[4] !== 2'd0) $display("FAIL hold_grant_second: got %0d expected 0", obs_grant[4]); else pass_n++;
      total_n++; if (obs_cyc[4] - obs_cyc[3] !== 2) $display("FAIL hold_bubble: got gap %0d expected 2", obs_cyc[4] - obs_cyc[3]); else pass_n++;
    end
    repeat (3) tick();
    flush_src();
  endtask

  task automatic test_backpressure();
    int h0;
    obs_n = 0;
    push_pkt(3, 1, 4);
    run_until(2, 20);
    m_axis_tready = 1'b0;
    h0 = head[3];
    for (int k = 0; k < 5; k++) begin
      tick();
      total_n++; if (m_axis_tdata !== exp_data({8'd3, 8'd1, 8'd2})) $display("FAIL bp_tdata[%0d]: got %h expected beat 2", k, m_axis_tdata[23:0]); else pass_n++;
      total_n++; if (m_tuser() !== exp_tuser(3, 2)) $display("FAIL bp_tuser[%0d]: got %h expected %h", k, m_tuser(), exp_tuser(3, 2)); else pass_n++;
      total_n++; if (m_axis_tvalid !== 1'b1) $display("FAIL bp_tvalid[%0d]: got %b expected 1", k, m_axis_tvalid); else pass_n++;
      total_n++; if (s_axis_tready[3] !== 1'b0) $display("FAIL bp_s_tready[%0d]: got %b expected 0", k, s_axis_tready[3]); else pass_n++;
    end
    total_n++; if (head[3] !== h0) $display("FAIL bp_no_accept: got head %0d expected %0d", head[3], h0); else pass_n++;
    m_axis_tready = 1'b1;
    run_until(4, 20);
    repeat (3) tick();
    total_n++; if (obs_n !== 4) $display("FAIL bp_count: got %0d expected 4", obs_n); else pass_n++;
    for (int i = 0; i < 4 && i < obs_n; i++) begin
      total_n++; if (obs_data[i] !== exp_data({8'd3, 8'd1, 8'(i)})) $display("FAIL bp_seq[%0d]: got %h expected port 3 beat %0d", i, obs_data[i][23:0], i); else pass_n++;
      total_n++; if (obs_last[i] !== (i == 3)) $display("FAIL bp_last[%0d]: got %b expected %b", i, obs_last[i], (i == 3)); else pass_n++;
    end
    flush_src();
  endtask

  task automatic test_reset_mid();
    obs_n = 0;
    push_pkt(2, 1, 4);
    run_until(2, 20);
    total_n++; if (busy !== 1'b1) $display("FAIL rst_mid_busy_before: got %b expected 1", busy); else pass_n++;
    axi_reset = 1'b1;
    #1;
    total_n++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_mid_tvalid: got %b expected 0", m_axis_tvalid); else pass_n++;
    total_n++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_n++;
    total_n++; if (grant_port !== 2'd0) $display("FAIL rst_mid_grant: got %0d expected 0", grant_port); else pass_n++;
    total_n++; if (s_axis_tready !== 4'b0000) $display("FAIL rst_mid_tready: got %b expected 0000", s_axis_tready); else pass_n++;
    flush_src();
    @(posedge axi_aclk);
    #1;
    axi_reset = 1'b0;
    obs_n = 0;
    push_pkt(0, 2, 1);
    push_pkt(3, 2, 1);
    run_until(2, 20);
    total_n++; if (obs_n !== 2) $display("FAIL rst_mid_count: got %0d expected 2", obs_n); else pass_n++;
    total_n++; if (obs_data[0] !== exp_data({8'd0, 8'd2, 8'd0})) $display("FAIL rst_mid_first: got %h expected port 0", obs_data[0][23:0]); else pass_n++;
    total_n++; if (obs_data[1] !== exp_data({8'd3, 8'd2, 8'd0})) $display("FAIL rst_mid_second: got %h expected port 3", obs_data[1][23:0]); else pass_n++;
    repeat (3) tick();
  endtask

  initial begin
    s_axis_tdata = '0;
    s_axis_tkeep_enc = '0;
    s_axis_tuser_packet_length = '0;
    s_axis_tuser_in_port = '0;
    s_axis_tuser_in_vport = '0;
    s_axis_tuser_out_port = '0;
    s_axis_tuser_out_vport = '0;
    s_axis_tvalid = '0;
    s_axis_tlast = '0;
    m_axis_tready = 1'b1;
    axi_reset = 1'b1;
    obs_n = 0;
    for (int i = 0; i < 1024; i++) vhist[i] = 1'b0;
    test_reset();
    test_round_robin();
    test_back_to_back();
    test_hold_off();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axis_packet_arbiter.md
AXIS_PACKET_ARBITER -- requirements
Module: axis_packet_arbiter

Interface
REQ-001 SHALL have parameters: C_NUM_PORTS, default 4, number of slave streams; C_AXIS_DATA_WIDTH, default 256, data width; C_TKEEP_ENC_WIDTH, default 5, encoded-tkeep width (log2 of C_AXIS_DATA_WIDTH/8); C_PACKET_LENGTH_WIDTH, default 14; C_INPORT_WIDTH, default 3; C_OUTPORT_WIDTH, default 8.
REQ-002 SHALL have ports: one clock; reset asynchronous, active-high:
- axi_aclk  in  1  clock, all logic on rising edge.
- axi_reset  in  1  asynchronous active-high reset.
- s_axis_tdata  in  N*C_AXIS_DATA_WIDTH  slave data; port i occupies slice i.
- s_axis_tkeep_enc  in  N*C_TKEEP_ENC_WIDTH  encoded tkeep per port.
- s_axis_tuser_packet_length  in  N*C_PACKET_LENGTH_WIDTH  per-port length.
- s_axis_tuser_in_port / s_axis_tuser_in_vport  in  N*C_INPORT_WIDTH each  per-port source fields.
- s_axis_tuser_out_port / s_axis_tuser_out_vport  in  N*C_OUTPORT_WIDTH each  per-port destination fields.
- s_axis_tvalid / s_axis_tlast  in  N  per-port valid, last.
- s_axis_tready  out  N  per-port ready.
- m_axis_tdata, m_axis_tkeep_enc, m_axis_tuser_packet_length, m_axis_tuser_in_port, m_axis_tuser_out_port, m_axis_tuser_in_vport, m_axis_tuser_out_vport  out  single-port widths as above  selected beat.
- m_axis_tvalid / m_axis_tlast  out  1  master valid, last.
- m_axis_tready  in  1  master ready.
- grant_port  out  log2(N)  currently/last granted port.
- busy  out  1  high while a packet is granted.

Function
REQ-003 SHALL arbitrate at packet granularity: once granted, a port keeps the grant until its tlast beat is accepted.
REQ-004 SHALL use FSM states IDLE and LOCKED; IDLE->LOCKED when any s_axis_tvalid is high; LOCKED->IDLE on accepted beat with tlast.
REQ-005 SHALL, in IDLE, pick the first port with tvalid high scanning from (last_grant+1) mod N upward with wrap; register winner into grant_port and last_grant on the transition.
REQ-006 SHALL drive s_axis_tready all zero in IDLE; in LOCKED drive only bit grant_port as (!m_axis_tvalid || m_axis_tready).
REQ-007 SHALL register every master output in a one-stage slice, loaded when (!m_axis_tvalid || m_axis_tready); all fields copied field-for-field from the granted port, no cross-wiring.
REQ-008 Latency: s_axis_tvalid high at edge k (IDLE) -> grant at k+1 -> first beat on m_axis at k+2; within a packet one beat per cycle when m_axis_tready stays high.
REQ-009 SHALL insert exactly one IDLE cycle between consecutive packets (arbitration bubble).
REQ-010 SHALL, with m_axis_tready low, hold all master outputs stable and accept no slave beat.
REQ-011 SHALL, if the granted port drops tvalid mid-packet, hold the grant indefinitely (no timeout), and m_axis_tvalid falls once the slice drains.
REQ-012 SHALL handle single-beat packets (tlast on first beat) with the same IDLE->LOCKED->IDLE sequence.
REQ-013 busy SHALL equal (state==LOCKED).

Reset
REQ-014 SHALL on axi_reset assertion immediately clear: state=IDLE, m_axis_tvalid=0, m_axis_tlast=0, all m_axis data/tuser registers=0, s_axis_tready=0, grant_port=0, last_grant=N-1.
REQ-015 Reset mid-packet SHALL discard the partial packet; upstream is reset by the same signal.

Structure
REQ-016 The log2 function SHALL come from the shared nf10_upb_lib include; no new package constants.
REQ-017 The output stage SHALL be a sub-module axis_reg_slice (one-stage AXIS register with encoded tkeep and tuser fields).

Verification
REQ-018 Reset then ports 0-3 each offer a 2-beat packet simultaneously -> packets emitted in order 0,1,2,3, one bubble cycle between, grant_port 0,1,2,3.
REQ-019 Only port 2 offers three 1-beat packets back-to-back -> all three granted to port 2, m_axis_tvalid pattern 1,0,1,0,1.
REQ-020 Port 1 streaming a 4-beat packet, port 0 asserts tvalid on beat 2 -> port 0 waits until port 1 tlast accepted, then granted.
REQ-021 m_axis_tready low for 5 cycles mid-packet -> m_axis_tdata/tuser unchanged, s_axis_tready[g]=0, no beat lost or duplicated.
REQ-022 axi_reset asserted on beat 2 of a 4-beat packet -> m_axis_tvalid=0 same cycle, busy=0, next arbitration starts from port 0.
